alu_issue: RTL and testbench

Command-side initiator for the combinational 32-bit ALU. It accepts operation commands over a valid/ready handshake and drives registered operands and a function code onto the ALU inputs. One cycle later it captures the ALU result and carry, and returns them in order through a result FIFO with backpressure. It sits between the datapath controller and the ALU, and allows one command per cycle when the response side is not stalled.

---
 rtl/alu_issue.sv | 123 ++++++++++++
 tb/tb_alu_issue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: registered command issue stage for a combinational 32-bit ALU, with an
// in-order result FIFO. Define ALU_FLAGS_EN to add per-entry rsp_zero / rsp_neg flags.
module alu_issue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [31:0]            cmd_a,
    input  logic [31:0]            cmd_b,
    input  logic [3:0]             cmd_fun,
    input  logic                   cmd_use_prev,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [3:0]             alu_fun,
    input  logic [31:0]            alu_y,
    input  logic                   alu_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_y,
    output logic                   rsp_cout,
    output logic                   rsp_err,
`ifdef ALU_FLAGS_EN
    output logic                   rsp_zero,
    output logic                   rsp_neg,
`endif
    output logic [$clog2(DEPTH):0] rsp_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [3:0] FUN_ADD = 4'd0;
    localparam logic [3:0] FUN_MAX = 4'd6;

    typedef struct packed {
        logic [31:0] y;
        logic        cout;
        logic        err;
`ifdef ALU_FLAGS_EN
        logic        zero;
        logic        neg;
`endif
    } entry_t;

    logic          s1_valid;
    logic [31:0]   prev_y;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    entry_t        mem [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic          rdy_d;
    logic [31:0]   a_d;
    logic [CW-1:0] cnt_d;
    entry_t        cap;

    // Capture formatting, operand forwarding and conservative credit for the next cycle
    always_comb begin
        accept   = cmd_valid && cmd_ready;
        push     = s1_valid;
        pop      = (cnt != '0) && rsp_ready;
        cap      = '0;
        cap.err  = (alu_fun > FUN_MAX);
        cap.y    = cap.err ? 32'd0 : alu_y;
        cap.cout = (alu_fun == FUN_ADD) && alu_cout;
`ifdef ALU_FLAGS_EN
        cap.zero = (cap.y == 32'd0);
        cap.neg  = cap.y[31];
`endif
        // The in-flight result is newer than prev_y, so it wins when S1 is occupied
        a_d      = cmd_use_prev ? (s1_valid ? cap.y : prev_y) : cmd_a;
        cnt_d    = cnt + CW'(push) - CW'(pop);
        rdy_d    = ({1'b0, cnt_d} + (CW + 1)'(accept)) < (CW + 1)'(DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            s1_valid  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= '0;
            prev_y    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            cmd_ready <= rdy_d;
            s1_valid  <= accept;
            cnt       <= cnt_d;
            if (accept) begin
                alu_a   <= a_d;
                alu_b   <= cmd_b;
                alu_fun <= cmd_fun;
            end
            if (push) begin
                mem[wr_ptr] <= cap;
                wr_ptr      <= wr_ptr + PW'(1);
                prev_y      <= cap.y;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    assign rsp_valid = (cnt != '0);
    assign rsp_count = cnt;
    assign rsp_y     = mem[rd_ptr].y;
    assign rsp_cout  = mem[rd_ptr].cout;
    assign rsp_err   = mem[rd_ptr].err;
`ifdef ALU_FLAGS_EN
    assign rsp_zero  = mem[rd_ptr].zero;
    assign rsp_neg   = mem[rd_ptr].neg;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized scoreboard bench for alu_issue with a behavioural ALU and
// a command-level reference model (expected results computed in command order).
module tb_alu_issue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [31:0]   cmd_a = '0;
    logic [31:0]   cmd_b = '0;
    logic [3:0]    cmd_fun = '0;
    logic          cmd_use_prev = 1'b0;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [3:0]    alu_fun;
    logic [31:0]   alu_y;
    logic          alu_cout;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_y;
    logic          rsp_cout;
    logic          rsp_err;
    logic [CW-1:0] rsp_count;
`ifdef ALU_FLAGS_EN
    logic          rsp_zero;
    logic          rsp_neg;
`endif

    typedef struct {
        logic [31:0] y;
        logic        cout;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_res = '0;
    int          total = 0;
    int          bad = 0;
    int          accepted = 0;

    alu_issue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun), .cmd_use_prev(cmd_use_prev),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_y(alu_y), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
`ifdef ALU_FLAGS_EN
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
        .rsp_count(rsp_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: carry is deliberately noisy for non-add and illegal codes
    always_comb begin
        logic [32:0] s;
        s        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_cout = 1'b1;
        case (alu_fun)
            4'd0: begin alu_y = s[31:0]; alu_cout = s[32]; end
            4'd1: alu_y = alu_a - alu_b;
            4'd2: alu_y = alu_a & alu_b;
            4'd3: alu_y = alu_a | alu_b;
            4'd4: alu_y = alu_a ^ alu_b;
            4'd5: alu_y = alu_a << alu_b[4:0];
            4'd6: alu_y = alu_a >> alu_b[4:0];
            default: alu_y = 32'hDEAD_BEEF;
        endcase
    end

    function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] f);
        exp_t r;
        longint unsigned wide;
        r.y = 32'd0; r.cout = 1'b0; r.err = 1'b0;
        if (f > 4'd6) begin
            r.err = 1'b1;
        end else begin
            case (f)
                4'd0: begin
                    wide   = longint'(a) + longint'(b);
                    r.y    = wide[31:0];
                    r.cout = (wide >= 64'h1_0000_0000);
                end
                4'd1: r.y = a - b;
                4'd2: r.y = a & b;
                4'd3: r.y = a | b;
                4'd4: r.y = a ^ b;
                4'd5: r.y = a << b[4:0];
                default: r.y = a >> b[4:0];
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Accept monitor: models each accepted command at command level
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            last_res = '0;
        end else if (cmd_valid && cmd_ready) begin
            exp_t e;
            e = ref_op(cmd_use_prev ? last_res : cmd_a, cmd_b, cmd_fun);
            last_res = e.y;
            sb.push_back(e);
            accepted++;
        end
    end

    // Response monitor: compares the FIFO head against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (rsp_count > CW'(DEPTH)) begin
                bad++;
                $display("FAIL count_bound: got %0d limit %0d", rsp_count, DEPTH);
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got y=0x%08h with empty scoreboard", rsp_y);
                end else begin
                    check("rsp_y", rsp_y, sb[0].y);
                    check("rsp_cout", 32'(rsp_cout), 32'(sb[0].cout));
                    check("rsp_err", 32'(rsp_err), 32'(sb[0].err));
`ifdef ALU_FLAGS_EN
                    check("rsp_zero", 32'(rsp_zero), 32'(sb[0].y == 32'd0));
                    check("rsp_neg", 32'(rsp_neg), 32'(sb[0].y[31]));
`endif
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f, input logic up);
        int n;
        n            = 0;
        cmd_valid    = 1'b1;
        cmd_a        = a;
        cmd_b        = b;
        cmd_fun      = f;
        cmd_use_prev = up;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL send_timeout: cmd_ready stayed 0 for %0d cycles", n);
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_cmd();
        logic [3:0] f;
        f = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) f = 4'($urandom_range(0, 6));
        send($urandom, $urandom, f, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_count", 32'(rsp_count), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_rsp_y", rsp_y, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // Single add with carry and latency
        rsp_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'd1, 4'd0, 1'b0);
        @(negedge clk);
        check("latency_n", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("latency_n1", 32'(rsp_valid), 32'd1);
        check("add_carry", 32'(rsp_cout), 32'd1);
        idle(2);

        // Forwarding chain, then illegal code followed by a use_prev add
        send(32'd5, 32'd3, 4'd0, 1'b0);
        send(32'd0, 32'd2, 4'd1, 1'b1);
        send(32'd7, 32'd9, 4'hA, 1'b0);
        send(32'd123, 32'd4, 4'd0, 1'b1);
        idle(4);
        send(32'd99, 32'd1, 4'd0, 1'b1);
        idle(4);

        // Backpressure: 6 commands with the consumer stalled
        rsp_ready = 1'b0;
        accepted  = 0;
        fork
            for (int i = 0; i < 6; i++) send(32'(i * 10), 32'd1, 4'd0, 1'b0);
            begin
                int n;
                n = 0;
                while (accepted < 4 && n < 100) begin @(posedge clk); n++; end
                idle(5);
                check("bp_accepted", 32'(accepted), 32'd4);
                check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
                check("bp_count", 32'(rsp_count), 32'd4);
                rsp_ready = 1'b1;
            end
        join
        idle(6);

        // Random stream with the consumer always ready
        for (int i = 0; i < 100; i++) rand_cmd();
        idle(6);

        // Random stream with random consumer stalls
        fork
            for (int i = 0; i < 100; i++) rand_cmd();
            repeat (400) begin
                @(posedge clk); #1;
                rsp_ready = 1'($urandom_range(0, 2) != 0);
            end
        join_any
        disable fork;
        rsp_ready = 1'b1;
        idle(10);

        // Async reset with 3 entries queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'(i + 1), 32'd1, 4'd0, 1'b0);
        idle(3);
        check("pre_rst_count", 32'(rsp_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_count", 32'(rsp_count), 32'd0);
        check("async_rst_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(32'd10, 32'd20, 4'd0, 1'b1);
        idle(4);

        // Drain
        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL drain: %0d responses missing, expected 0", sb.size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
